dct_transpose_buf: RTL and testbench

- Sits between the row pass and the column pass of the 8x8 2D DCT.
- Accepts one 8-coefficient row-pass result per handshake and rescales each coefficient to the column-pass input width.
- Stores a full 8x8 block in a ping-pong buffer and emits it column by column as packed 8-lane vectors for the column pass.
- Provides full-rate streaming: one row in and one column out per cycle.

---
 rtl/dct_transpose_buf.sv | 121 ++++++++++++
 tb/tb_dct_transpose_buf.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/dct_transpose_buf.sv
// 8x8 DCT transpose buffer: rescales row-pass rows, stores them ping-pong and emits columns; first column 1 cycle after row 8.
// Backpressure: in_ready drops only when both banks are full; columns hold stable while out_ready is low.
module dct_transpose_buf #(
  parameter int IN_W  = 12,
  parameter int OUT_W = 8,
  parameter int SHIFT = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [8*IN_W-1:0]  in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [8*OUT_W-1:0] out_data,
  output logic [2:0]         out_col,
  output logic               out_last,
  output logic [7:0]         sat_cnt
);
  localparam int TW = IN_W + 1;
  localparam logic signed [TW-1:0] RND   = TW'(2 ** (SHIFT - 1));
  localparam logic signed [TW-1:0] MAX_V = TW'(2 ** (OUT_W - 1) - 1);
  localparam logic signed [TW-1:0] MIN_V = ~MAX_V;

  logic [OUT_W-1:0] mem [2][8][8];
  logic [1:0]       full;
  logic             wbank;
  logic             rbank;
  logic [2:0]       wrow;
  logic [2:0]       rcol;
  logic             wr_fire;
  logic             rd_fire;

  logic signed [TW-1:0] x_ext [8];
  logic signed [TW-1:0] t_val [8];
  logic [OUT_W-1:0]     conv  [8];
  logic [7:0]           sat_lane;
  logic [3:0]           sat_sum;
  logic [8:0]           sat_add;

  assign in_ready  = !full[wbank];
  assign out_valid = full[rbank];
  assign out_col   = rcol;
  assign out_last  = out_valid && (rcol == 3'd7);
  assign wr_fire   = in_valid && in_ready;
  assign rd_fire   = out_valid && out_ready;

  // Round half up, then clamp to the signed output range.
  always_comb begin
    sat_lane = '0;
    sat_sum  = '0;
    for (int c = 0; c < 8; c++) begin
      x_ext[c] = {in_data[(8-c)*IN_W-1], in_data[(7-c)*IN_W +: IN_W]};
      t_val[c] = (x_ext[c] + RND) >>> SHIFT;
      if (t_val[c] > MAX_V) begin
        conv[c]     = MAX_V[OUT_W-1:0];
        sat_lane[c] = 1'b1;
      end else if (t_val[c] < MIN_V) begin
        conv[c]     = MIN_V[OUT_W-1:0];
        sat_lane[c] = 1'b1;
      end else begin
        conv[c] = t_val[c][OUT_W-1:0];
      end
      sat_sum = sat_sum + {3'b000, sat_lane[c]};
    end
    sat_add = {1'b0, sat_cnt} + {5'b00000, sat_sum};
  end

  always_comb begin
    out_data = '0;
    for (int r = 0; r < 8; r++) begin
      out_data[(7-r)*OUT_W +: OUT_W] = mem[rbank][r][rcol];
    end
  end

  // Write and read complete on different banks, so both flag updates can land together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full    <= '0;
      wbank   <= 1'b0;
      rbank   <= 1'b0;
      wrow    <= '0;
      rcol    <= '0;
      sat_cnt <= '0;
      for (int b = 0; b < 2; b++) begin
        for (int r = 0; r < 8; r++) begin
          for (int c = 0; c < 8; c++) begin
            mem[b][r][c] <= '0;
          end
        end
      end
    end else if (flush) begin
      full    <= '0;
      wbank   <= 1'b0;
      rbank   <= 1'b0;
      wrow    <= '0;
      rcol    <= '0;
      sat_cnt <= '0;
    end else begin
      if (wr_fire) begin
        for (int c = 0; c < 8; c++) begin
          mem[wbank][wrow][c] <= conv[c];
        end
        sat_cnt <= sat_add[8] ? 8'hFF : sat_add[7:0];
        wrow    <= wrow + 3'd1;
        if (wrow == 3'd7) begin
          full[wbank] <= 1'b1;
          wbank       <= ~wbank;
        end
      end
      if (rd_fire) begin
        rcol <= rcol + 3'd1;
        if (rcol == 3'd7) begin
          full[rbank] <= 1'b0;
          rbank       <= ~rbank;
        end
      end
    end
  end
endmodule

// File: tb/tb_dct_transpose_buf.sv
// Directed bench for dct_transpose_buf: block transpose, rounding/saturation, streaming, backpressure, flush, reset.
module tb_dct_transpose_buf;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [95:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_data;
  logic [2:0]  out_col;
  logic        out_last;
  logic [7:0]  sat_cnt;

  int n_checks = 0;
  int n_pass = 0;
  int stall_cycles = 0;
  int cyc_now = 0;
  int first_cyc = -1;
  int last_cyc = -1;
  int vld_seen = 0;
  logic [63:0] exp2 [8];

  dct_transpose_buf dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_col(out_col), .out_last(out_last), .sat_cnt(sat_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_now <= cyc_now + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [95:0] mk_row(input int r, input int off);
    logic [95:0] v = '0;
    for (int c = 0; c < 8; c++) v[(7-c)*12 +: 12] = 12'(16 * (8*r + c - off));
    return v;
  endfunction

  function automatic logic [63:0] col_exp(input int j, input int off);
    logic [63:0] v = '0;
    for (int r = 0; r < 8; r++) v[(7-r)*8 +: 8] = 8'(8*r + j - off);
    return v;
  endfunction

  task automatic send_row(input logic [95:0] d);
    int  w = 0;
    bit  acc;
    in_valid = 1'b1;
    in_data  = d;
    do begin
      acc = in_ready;
      if (!acc) stall_cycles++;
      step();
      w++;
    end while (!acc && w < 200);
    if (!acc) check("send_timeout", 64'(acc), 64'(1));
    in_valid = 1'b0;
  endtask

  // Expects out_ready held high so every presented column is accepted.
  task automatic read_block(input int off, input bit use_t2, input string tag);
    int got = 0;
    int cyc = 0;
    logic [63:0] e;
    while (got < 8 && cyc < 300) begin
      if (out_valid) begin
        e = use_t2 ? exp2[got] : col_exp(got, off);
        check({tag, "_col"}, 64'(out_col), 64'(got));
        check({tag, "_data"}, out_data, e);
        check({tag, "_last"}, 64'(out_last), 64'(got == 7));
        if (first_cyc < 0) first_cyc = cyc_now;
        last_cyc = cyc_now;
        got++;
      end
      step();
      cyc++;
    end
    if (got < 8) check({tag, "_timeout"}, 64'(got), 64'(8));
  endtask

  initial begin
    exp2[0] = 64'h7F00_0000_0000_0000;
    exp2[1] = 64'h8000_0000_0000_0000;
    exp2[2] = 64'h0200_0000_0000_0000;
    exp2[3] = 64'h0100_0000_0000_0000;
    exp2[4] = 64'hFF00_0000_0000_0000;
    exp2[5] = 64'h0;
    exp2[6] = 64'h0;
    exp2[7] = 64'h0;

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("rst_in_ready", 64'(in_ready), 64'(1));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out_col", 64'(out_col), 64'(0));
    check("rst_out_last", 64'(out_last), 64'(0));
    check("rst_sat_cnt", 64'(sat_cnt), 64'(0));
    check("rst_out_data", out_data, 64'h0);

    // Single block transpose
    out_ready = 1'b1;
    for (int r = 0; r < 8; r++) begin
      if (r == 7) check("t1_not_early", 64'(out_valid), 64'(0));
      send_row(mk_row(r, 0));
    end
    check("t1_latency", 64'(out_valid), 64'(1));
    read_block(0, 1'b0, "t1");
    check("t1_sat_cnt", 64'(sat_cnt), 64'(0));

    // Rounding and saturation
    send_row({12'h7FF, 12'h800, 12'h018, 12'h017, 12'hFE8, 12'hFF8, 12'h007, 12'h000});
    check("t2_sat_cnt_row", 64'(sat_cnt), 64'(1));
    for (int r = 1; r < 8; r++) send_row(96'h0);
    read_block(0, 1'b1, "t2");
    check("t2_sat_cnt", 64'(sat_cnt), 64'(1));

    // Three blocks streamed back to back
    stall_cycles = 0;
    first_cyc = -1;
    fork
      begin
        for (int b = 0; b < 3; b++)
          for (int r = 0; r < 8; r++) send_row(mk_row(r, 32*b));
      end
      begin
        for (int b = 0; b < 3; b++) read_block(32*b, 1'b0, "t3");
      end
    join
    check("t3_in_ready_stalls", 64'(stall_cycles), 64'(0));
    check("t3_contiguous_span", 64'(last_cyc - first_cyc), 64'(23));

    // Both banks fill while the reader is stalled
    out_ready = 1'b0;
    stall_cycles = 0;
    for (int b = 0; b < 2; b++)
      for (int r = 0; r < 8; r++) send_row(mk_row(r, 32*b));
    check("t4_no_stall_16", 64'(stall_cycles), 64'(0));
    check("t4_in_ready_low", 64'(in_ready), 64'(0));
    check("t4_valid", 64'(out_valid), 64'(1));
    check("t4_data_a", out_data, col_exp(0, 0));
    repeat (3) step();
    check("t4_data_hold", out_data, col_exp(0, 0));
    check("t4_col_hold", 64'(out_col), 64'(0));
    check("t4_in_ready_still_low", 64'(in_ready), 64'(0));
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("t4_pulse_col", 64'(out_col), 64'(i));
      check("t4_pulse_data", out_data, col_exp(i, 0));
      if (i == 7) check("t4_in_ready_not_comb", 64'(in_ready), 64'(0));
      step();
    end
    check("t4_in_ready_back", 64'(in_ready), 64'(1));
    read_block(32, 1'b0, "t4b");

    // Partial saturating block discarded by flush
    for (int r = 0; r < 5; r++) send_row({8{12'h7FF}});
    check("t5_sat_before_flush", 64'(sat_cnt), 64'(41));
    check("t5_no_out_partial", 64'(out_valid), 64'(0));
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("t5_sat_flushed", 64'(sat_cnt), 64'(0));
    check("t5_in_ready", 64'(in_ready), 64'(1));
    check("t5_out_valid", 64'(out_valid), 64'(0));
    for (int r = 0; r < 8; r++) send_row(mk_row(r, 0));
    read_block(0, 1'b0, "t5");
    check("t5_sat_after", 64'(sat_cnt), 64'(0));

    // sat_cnt clamps at 255
    for (int r = 0; r < 31; r++) send_row({8{12'h7FF}});
    check("t6_sat_248", 64'(sat_cnt), 64'(248));
    send_row({8{12'h7FF}});
    check("t6_sat_clamp", 64'(sat_cnt), 64'(255));
    repeat (12) step();
    check("t6_drained", 64'(out_valid), 64'(0));

    // Asynchronous reset during column 3
    for (int r = 0; r < 8; r++) send_row(mk_row(r, 0));
    repeat (3) step();
    check("t7_col3", 64'(out_col), 64'(3));
    rst_n = 1'b0;
    #1;
    check("t7_rst_valid", 64'(out_valid), 64'(0));
    check("t7_rst_col", 64'(out_col), 64'(0));
    check("t7_rst_sat", 64'(sat_cnt), 64'(0));
    check("t7_rst_data", out_data, 64'h0);
    check("t7_rst_in_ready", 64'(in_ready), 64'(1));
    @(posedge clk);
    #1 rst_n = 1'b1;
    vld_seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid) vld_seen++;
      step();
    end
    check("t7_quiet", 64'(vld_seen), 64'(0));
    for (int r = 0; r < 8; r++) send_row(mk_row(r, 32));
    read_block(32, 1'b0, "t7");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
